// File: rtl/between_link_pkg.sv
// Shared types and constants for the "between" inter-board link (tx and future rx).
package between_link_pkg;

    // Width of the saturating dropped-word counter.
    localparam int DROP_W = 8;

    // Transmit handshake phases.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Bits needed for a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/between_link_tx_if.sv
// Local push port plus the physical link wires of the between link.
interface between_link_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] t_data;
    logic              tsent;
    logic              trecieve;

    // Transmitter side: accepts words, drives the link, sees the acknowledge.
    modport master (
        input  in_data,
        input  in_valid,
        input  trecieve,
        output in_ready,
        output t_data,
        output tsent
    );

    // Environment side: supplies words and plays the remote receiver.
    modport slave (
        output in_data,
        output in_valid,
        output trecieve,
        input  in_ready,
        input  t_data,
        input  tsent
    );
endinterface

// File: rtl/between_link_tx_sync_fifo.sv
// Single-clock FIFO with registered occupancy; head word is read combinationally.
module sync_fifo
    import between_link_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = cnt_w(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push_s;
    logic              do_pop_s;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == {LVL_W{1'b0}});
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // Qualify requests and compute next pointers and occupancy; a full FIFO refuses even when popping.
    always_comb begin
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/between_link_tx.sv
// Transmit side of the between link: buffers words and sends each one with a
// four-phase tsent/trecieve handshake, setup delay and per-phase timeout.
module between_link_tx
    import between_link_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int SETUP_CYC   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    between_link_tx_if.master      lnk,
    output logic                   idle,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err_timeout,
    input  logic                   err_clr,
    output logic [DROP_W-1:0]      drop_count
);
    localparam int                CNT_W      = cnt_w(SETUP_CYC);
    localparam int                TCNT_W     = cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam bit                TO_EN      = (TIMEOUT > 0);
    localparam logic [TCNT_W-1:0] TO_LAST    = (TIMEOUT > 0) ? TCNT_W'(TIMEOUT - 1) : {TCNT_W{1'b0}};

    state_t                   state_q, state_d;
    logic [DATA_W-1:0]        t_data_q, t_data_d;
    logic                     tsent_q, tsent_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [TCNT_W-1:0]        tcnt_q, tcnt_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     err_q, err_d;
    logic [DROP_W-1:0]        drop_q, drop_d;

    logic                     ack_s;
    logic                     pop_s;
    logic                     timeout_s;
    logic                     full_s;
    logic                     empty_s;
    logic [DATA_W-1:0]        head_s;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (lnk.in_valid),
        .pop   (pop_s),
        .wdata (lnk.in_data),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

    assign lnk.in_ready = ~full_s;
    assign lnk.t_data   = t_data_q;
    assign lnk.tsent    = tsent_q;
    assign idle         = empty_s & (state_q == IDLE);
    assign err_timeout  = err_q;
    assign drop_count   = drop_q;
    assign ack_s        = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous acknowledge through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], lnk.trecieve};
    end

    // Handshake sequencing: load word, hold setup, request, wait for release, with timeout abort.
    always_comb begin
        state_d   = state_q;
        t_data_d  = t_data_q;
        tsent_d   = tsent_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        pop_s     = 1'b0;
        timeout_s = 1'b0;
        case (state_q)
            IDLE: begin
                tsent_d = 1'b0;
                if (!empty_s) begin
                    t_data_d = head_s;
                    pop_s    = 1'b1;
                    cnt_d    = SETUP_LAST;
                    state_d  = SETUP;
                end else begin
                    state_d  = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    tsent_d = 1'b1;
                    tcnt_d  = {TCNT_W{1'b0}};
                    state_d = REQ;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            REQ: begin
                if (ack_s) begin
                    tsent_d = 1'b0;
                    tcnt_d  = {TCNT_W{1'b0}};
                    state_d = RELEASE;
                end else if (TO_EN && (tcnt_q == TO_LAST)) begin
                    timeout_s = 1'b1;
                    tsent_d   = 1'b0;
                    state_d   = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            RELEASE: begin
                tsent_d = 1'b0;
                if (!ack_s) begin
                    state_d = IDLE;
                end else if (TO_EN && (tcnt_q == TO_LAST)) begin
                    timeout_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            default: begin
                tsent_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Sticky error flag and saturating drop counter; a timeout beats a same-cycle clear.
    always_comb begin
        err_d  = err_q;
        drop_d = drop_q;
        if (timeout_s) begin
            err_d = 1'b1;
            if (drop_q != {DROP_W{1'b1}}) begin
                drop_d = drop_q + DROP_W'(1);
            end else begin
                drop_d = drop_q;
            end
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State, link output and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            t_data_q <= {DATA_W{1'b0}};
            tsent_q  <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            tcnt_q   <= {TCNT_W{1'b0}};
            sync_q   <= {SYNC_STAGES{1'b0}};
            err_q    <= 1'b0;
            drop_q   <= {DROP_W{1'b0}};
        end else begin
            state_q  <= state_d;
            t_data_q <= t_data_d;
            tsent_q  <= tsent_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            sync_q   <= sync_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_between_link_tx.sv
// Self-checking bench for between_link_tx. The reference model keeps the FIFO as a
// queue and derives every link event edge from the handshake timing rules.
module tb_between_link_tx;
    import between_link_pkg::*;

    localparam int DATA_W      = 8;
    localparam int DEPTH       = 16;
    localparam int SETUP_CYC   = 2;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 8;
    localparam int LVL_W       = $clog2(DEPTH) + 1;

    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_STUCK  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              idle;
    logic [LVL_W-1:0]  level;
    logic              err_timeout;
    logic              err_clr;
    logic [DROP_W-1:0] drop_count;

    between_link_tx_if #(.DATA_W(DATA_W)) lnk_if ();

    between_link_tx #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SETUP_CYC   (SETUP_CYC),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lnk         (lnk_if),
        .idle        (idle),
        .level       (level),
        .err_timeout (err_timeout),
        .err_clr     (err_clr),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Reference model state.
    logic [DATA_W-1:0] mq [$];
    logic [DATA_W-1:0] tdata_exp;
    int err_exp, drops_exp;
    // Edge numbers of the in-flight word: tsent rise/fall, ack high window, FSM back in IDLE, timeout.
    int r_e, f_e, a_e, aend_e, x_e, t_e;
    int rx_mode;
    bit rx_rand;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_model();
        mq.delete();
        tdata_exp = '0;
        err_exp   = 0;
        drops_exp = 0;
        r_e = 0; f_e = 0; a_e = 0; aend_e = 0; x_e = 0; t_e = -1;
    endtask

    // Plan the whole handshake of a word popped at edge p, including receiver behaviour.
    task automatic schedule(input int p);
        int mode, d, r, k;
        mode = rx_mode;
        if (rx_rand) begin
            k = $urandom_range(0, 9);
            mode = (k < 7) ? M_NORMAL : ((k < 9) ? M_NEVER : M_STUCK);
        end
        r_e = p + SETUP_CYC;
        d = $urandom_range(1, 4);
        r = $urandom_range(0, 3);
        case (mode)
            M_NEVER: begin
                a_e = 0; aend_e = 0;
                f_e = r_e + TIMEOUT;
                x_e = f_e;
                t_e = f_e;
            end
            M_STUCK: begin
                a_e    = r_e + d;
                f_e    = a_e + SYNC_STAGES;
                x_e    = f_e + TIMEOUT;
                t_e    = x_e;
                aend_e = x_e + 1;
            end
            default: begin
                a_e    = r_e + d;
                f_e    = a_e + SYNC_STAGES;
                aend_e = f_e + 1 + r;
                x_e    = aend_e + SYNC_STAGES;
                t_e    = -1;
            end
        endcase
    endtask

    // Advance one clock edge, update the model, compare every output, then drive the receiver.
    task automatic step();
        int e;
        bit acc, pop;
        e   = cyc + 1;
        acc = lnk_if.in_valid && (mq.size() < DEPTH);
        pop = (mq.size() > 0) && (e > x_e);
        @(posedge clk);
        #1;
        cyc = e;
        if (reset) begin
            clear_model();
        end else begin
            if (e == t_e) begin
                err_exp = 1;
                if (drops_exp < 255) drops_exp++;
            end else if (err_clr) begin
                err_exp = 0;
            end
            if (pop) begin
                tdata_exp = mq.pop_front();
                schedule(e);
            end
            if (acc) mq.push_back(lnk_if.in_data);
        end
        chk("level",    32'(level),            32'(mq.size()));
        chk("in_ready", 32'(lnk_if.in_ready),  32'(mq.size() < DEPTH));
        chk("idle",     32'(idle),             32'((mq.size() == 0) && (cyc >= x_e)));
        chk("tsent",    32'(lnk_if.tsent),     32'((cyc >= r_e) && (cyc < f_e)));
        chk("t_data",   32'(lnk_if.t_data),    32'(tdata_exp));
        chk("err",      32'(err_timeout),      32'(err_exp));
        chk("drops",    32'(drop_count),       32'(drops_exp));
        lnk_if.trecieve = ((cyc + 1) >= a_e) && ((cyc + 1) < aend_e);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        lnk_if.in_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ((mq.size() == 0) && (cyc >= x_e) && (cyc >= f_e)) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) chk("drain_bound", 32'(0), 32'(1));
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        lnk_if.in_valid = 1'b1;
        lnk_if.in_data  = w;
        step();
        lnk_if.in_valid = 1'b0;
    endtask

    initial begin
        int n_edge;
        bit hit;
        reset           = 1'b1;
        err_clr         = 1'b0;
        lnk_if.in_valid = 1'b0;
        lnk_if.in_data  = '0;
        lnk_if.trecieve = 1'b0;
        rx_mode         = M_NORMAL;
        rx_rand         = 1'b0;
        clear_model();

        repeat (2) step();
        chk("rst_tsent", 32'(lnk_if.tsent), 32'(0));
        chk("rst_idle",  32'(idle),         32'(1));
        reset = 1'b0;
        step();

        // Single word 0xA5.
        push_word(8'hA5);
        n_edge = cyc;
        chk("single_level", 32'(level), 32'(1));
        step();
        chk("single_tdata", 32'(lnk_if.t_data), 32'(8'hA5));
        chk("single_tsent_low", 32'(lnk_if.tsent), 32'(0));
        step();
        step();
        chk("single_tsent_rise", 32'(lnk_if.tsent), 32'(cyc == n_edge + 1 + SETUP_CYC));
        drain();
        chk("single_idle", 32'(idle), 32'(1));

        // Burst of 20 words into a 16-deep FIFO.
        for (int i = 0; i < 20; i++) begin
            lnk_if.in_valid = 1'b1;
            lnk_if.in_data  = DATA_W'($urandom);
            step();
        end
        drain();
        chk("burst_level", 32'(level), 32'(0));

        // Receiver never acknowledges: two words time out in REQ.
        rx_mode = M_NEVER;
        lnk_if.in_valid = 1'b1;
        lnk_if.in_data  = 8'h3C;
        step();
        lnk_if.in_data  = 8'hC3;
        step();
        drain();
        chk("to_err",   32'(err_timeout), 32'(1));
        chk("to_drops", 32'(drop_count),  32'(2));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to_clear", 32'(err_timeout), 32'(0));

        // Clear requested on the very edge a timeout fires.
        push_word(8'h5A);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (t_e == cyc + 1) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        if (!hit) chk("clr_wait", 32'(0), 32'(1));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_vs_timeout", 32'(err_timeout), 32'(1));
        drain();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Acknowledge stuck high through RELEASE.
        rx_mode = M_STUCK;
        push_word(8'h81);
        drain();
        chk("stuck_err",   32'(err_timeout), 32'(1));
        chk("stuck_drops", 32'(drop_count),  32'(4));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Reset while a word is in REQ and five more are queued.
        rx_mode = M_NORMAL;
        for (int i = 0; i < 6; i++) begin
            lnk_if.in_valid = 1'b1;
            lnk_if.in_data  = DATA_W'(8'h10 + i);
            step();
        end
        lnk_if.in_valid = 1'b0;
        chk("pre_rst_level", 32'(level),        32'(5));
        chk("pre_rst_tsent", 32'(lnk_if.tsent), 32'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_tsent", 32'(lnk_if.tsent),    32'(0));
        chk("rst_mid_level", 32'(level),           32'(0));
        chk("rst_mid_tdata", 32'(lnk_if.t_data),   32'(0));
        chk("rst_mid_drops", 32'(drop_count),      32'(0));
        chk("rst_mid_ready", 32'(lnk_if.in_ready), 32'(1));
        repeat (10) step();

        // Randomised traffic with a random receiver per word.
        rx_rand = 1'b1;
        for (int i = 0; i < 600; i++) begin
            lnk_if.in_valid = ($urandom_range(0, 3) != 0);
            lnk_if.in_data  = DATA_W'($urandom);
            err_clr         = ($urandom_range(0, 15) == 0);
            step();
        end
        err_clr = 1'b0;
        drain();
        chk("final_level", 32'(level), 32'(0));
        chk("final_idle",  32'(idle),  32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
